// File: rtl/fp_sub_pipe_if.sv
// Operand/result bundle for fp_sub_pipe: operands in, difference and flags out.
// in_valid qualifies a/b on the edge it is sampled; out_valid qualifies out/ovf/zero; there is no ready in either direction.
interface fp_sub_pipe_if;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] out;
  logic        ovf;
  logic        zero;

  modport master (output in_valid, a, b, input out_valid, out, ovf, zero);
  modport slave  (input in_valid, a, b, output out_valid, out, ovf, zero);
endinterface

// File: rtl/fp_sub_pipe.sv
// Four-stage IEEE-754 single-precision subtractor (a - b), round-to-nearest-even, subnormals flushed to zero.
// Define FP_SUB_SPECIAL_EN to compile in NaN/infinity handling; otherwise exponent 255 is an ordinary value.
module fp_sub_pipe #(
  parameter int FLUSH_DENORM = 1
) (
  input  logic          clock,
  input  logic          reset,
  fp_sub_pipe_if.slave  bus
);

  if (FLUSH_DENORM != 1) begin : g_flush_check
    $error("fp_sub_pipe: only FLUSH_DENORM=1 is supported");
  end

  // S1: unpack, flip sign of b, order operands by magnitude
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;
  logic        w_sa, w_sb, w_a_ge;
  logic        w_spec;
  logic [31:0] w_spec_val;

  assign w_ea   = bus.a[30:23];
  assign w_eb   = bus.b[30:23];
  assign w_ma   = (w_ea == 8'd0) ? 24'd0 : {1'b1, bus.a[22:0]};
  assign w_mb   = (w_eb == 8'd0) ? 24'd0 : {1'b1, bus.b[22:0]};
  assign w_sa   = bus.a[31];
  assign w_sb   = ~bus.b[31];
  assign w_a_ge = {w_ea, w_ma} >= {w_eb, w_mb};

`ifdef FP_SUB_SPECIAL_EN
  logic w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  assign w_inf_a = (w_ea == 8'hFF) && (bus.a[22:0] == 23'd0);
  assign w_inf_b = (w_eb == 8'hFF) && (bus.b[22:0] == 23'd0);
  assign w_nan_a = (w_ea == 8'hFF) && (bus.a[22:0] != 23'd0);
  assign w_nan_b = (w_eb == 8'hFF) && (bus.b[22:0] != 23'd0);

  always_comb begin
    w_spec     = 1'b0;
    w_spec_val = 32'd0;
    if (w_nan_a || w_nan_b) begin
      w_spec     = 1'b1;
      w_spec_val = 32'h7FC0_0000;
    end else if (w_inf_a && w_inf_b) begin
      w_spec     = 1'b1;
      w_spec_val = (bus.a[31] == bus.b[31]) ? 32'h7FC0_0000 : bus.a;
    end else if (w_inf_a) begin
      w_spec     = 1'b1;
      w_spec_val = bus.a;
    end else if (w_inf_b) begin
      w_spec     = 1'b1;
      w_spec_val = {~bus.b[31], 8'hFF, 23'd0};
    end
  end
`else
  assign w_spec     = 1'b0;
  assign w_spec_val = 32'd0;
`endif

  logic        r1_v, r2_v, r3_v;
  logic        r1_sl, r1_sub, r1_spec;
  logic [7:0]  r1_el, r1_es;
  logic [23:0] r1_ml, r1_ms;
  logic [31:0] r1_spec_val;

  // S2: align the smaller mantissa; everything past the guard/round bits folds into sticky
  logic [7:0]  w_ediff;
  logic [52:0] w_ext;
  logic [26:0] w_aligned;

  assign w_ediff   = r1_el - r1_es;
  assign w_ext     = {r1_ms, 29'd0} >> w_ediff;
  assign w_aligned = (w_ediff >= 8'd26) ? {26'd0, |r1_ms}
                                        : {w_ext[52:27], w_ext[26] | (|w_ext[25:0])};

  logic        r2_sl, r2_sub, r2_spec;
  logic [7:0]  r2_el;
  logic [23:0] r2_ml;
  logic [26:0] r2_ms;
  logic [31:0] r2_spec_val;

  // S3: magnitude add/subtract; large >= small so the difference never goes negative
  logic [27:0] w_sum;
  assign w_sum = r2_sub ? ({1'b0, r2_ml, 3'd0} - {1'b0, r2_ms})
                        : ({1'b0, r2_ml, 3'd0} + {1'b0, r2_ms});

  logic        r3_sl, r3_sub, r3_spec;
  logic [7:0]  r3_el;
  logic [27:0] r3_sum;
  logic [31:0] r3_spec_val;

  // S4: normalize so bit 27 is the leading one, then round on bits [3:0]
  logic [4:0]  w_lz;
  logic [27:0] w_norm;
  logic        w_up, w_carry;
  logic [22:0] w_frac;
  logic [9:0]  w_exp;
  logic [31:0] w_res;
  logic        w_ovf, w_zero;

  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 28; i++) begin
      if (r3_sum[i]) w_lz = 5'(27 - i);
    end
  end

  assign w_norm            = r3_sum << w_lz;
  assign w_up              = w_norm[3] & (w_norm[4] | w_norm[2] | w_norm[1] | w_norm[0]);
  assign {w_carry, w_frac} = {1'b0, w_norm[26:4]} + 24'(w_up);
  assign w_exp             = {2'b00, r3_el} + 10'd1 + {9'd0, w_carry} - {5'd0, w_lz};

  always_comb begin
    w_res  = {r3_sl, w_exp[7:0], w_frac};
    w_ovf  = 1'b0;
    w_zero = 1'b0;
    if (r3_spec) begin
      w_res = r3_spec_val;
    end else if (!w_norm[27]) begin
      w_res  = {~r3_sub & r3_sl, 31'd0};
      w_zero = 1'b1;
    end else if (w_exp[9] || (w_exp == 10'd0)) begin
      w_res  = {r3_sl, 31'd0};
      w_zero = 1'b1;
    end else if (w_exp >= 10'd255) begin
      w_res = {r3_sl, 8'hFF, 23'd0};
      w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r1_v          <= 1'b0;
      r2_v          <= 1'b0;
      r3_v          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out       <= 32'd0;
      bus.ovf       <= 1'b0;
      bus.zero      <= 1'b0;
    end else begin
      r1_v          <= bus.in_valid;
      r2_v          <= r1_v;
      r3_v          <= r2_v;
      bus.out_valid <= r3_v;
      if (r3_v) begin
        bus.out  <= w_res;
        bus.ovf  <= w_ovf;
        bus.zero <= w_zero;
      end
    end
  end

  always_ff @(posedge clock) begin
    r1_sl       <= w_a_ge ? w_sa : w_sb;
    r1_el       <= w_a_ge ? w_ea : w_eb;
    r1_ml       <= w_a_ge ? w_ma : w_mb;
    r1_es       <= w_a_ge ? w_eb : w_ea;
    r1_ms       <= w_a_ge ? w_mb : w_ma;
    r1_sub      <= w_sa ^ w_sb;
    r1_spec     <= w_spec;
    r1_spec_val <= w_spec_val;
    r2_sl       <= r1_sl;
    r2_el       <= r1_el;
    r2_ml       <= r1_ml;
    r2_ms       <= w_aligned;
    r2_sub      <= r1_sub;
    r2_spec     <= r1_spec;
    r2_spec_val <= r1_spec_val;
    r3_sl       <= r2_sl;
    r3_el       <= r2_el;
    r3_sum      <= w_sum;
    r3_sub      <= r2_sub;
    r3_spec     <= r2_spec;
    r3_spec_val <= r2_spec_val;
  end

endmodule

// File: tb/tb_fp_sub_pipe.sv
// Bench for fp_sub_pipe: directed vectors plus random operands scored against an exact big-integer model.
// Expected results are {out, ovf, zero}, queued with the cycle they must appear on.
module tb_fp_sub_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  fp_sub_pipe_if bus();

  fp_sub_pipe #(.FLUSH_DENORM(1)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [33:0] exp_q[$];
  int          due_q[$];
  logic [33:0] last_exp = '0;
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Exact value as an integer multiple of 2^-149, then rounded to 24 significant bits.
  function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, sr;
    int ea, eb, p, sh, e;
    logic [299:0] ma, mb, mag, keep, rem, half;
    sa = a[31];
    sb = ~b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
`ifdef FP_SUB_SPECIAL_EN
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return {32'h7FC0_0000, 2'b00};
    if (ea == 255 && eb == 255) return (a[31] == b[31]) ? {32'h7FC0_0000, 2'b00} : {a, 2'b00};
    if (ea == 255) return {a, 2'b00};
    if (eb == 255) return {~b[31], 8'hFF, 23'd0, 2'b00};
`endif
    ma = '0;
    mb = '0;
    if (ea != 0) ma = 300'({1'b1, a[22:0]}) << (ea - 1);
    if (eb != 0) mb = 300'({1'b1, b[22:0]}) << (eb - 1);
    if (sa == sb) begin
      mag = ma + mb; sr = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; sr = sa;
    end else begin
      mag = mb - ma; sr = sb;
    end
    if (mag == 0) return {(sa & sb), 31'd0, 2'b01};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (p > 23) begin
      sh   = p - 23;
      keep = mag >> sh;
      rem  = mag - (keep << sh);
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
      if (keep[24]) begin
        keep = keep >> 1;
        e    = e + 1;
      end
    end else begin
      keep = mag << (23 - p);
    end
    if (e >= 255) return {sr, 8'hFF, 23'd0, 2'b10};
    if (e <= 0) return {sr, 31'd0, 2'b01};
    return {sr, 8'(e), keep[22:0], 2'b00};
  endfunction

  function automatic logic [31:0] rnd_fp(input int near);
    int e, sel;
    logic [22:0] m;
    sel = $urandom_range(0, 15);
    if (sel == 0) e = 0;
    else if (sel == 1) e = $urandom_range(250, 255);
    else if (sel < 10) begin
      e = near + $urandom_range(0, 6) - 3;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end else e = $urandom_range(1, 254);
    m = 23'($urandom);
    if ($urandom_range(0, 3) == 0) m = m & 23'h7F0000;
    return {1'($urandom_range(0, 1)), 8'(e), m};
  endfunction

  task automatic send(input logic [31:0] a_i, input logic [31:0] b_i, input logic [33:0] want);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b1;
    bus.a        = a_i;
    bus.b        = b_i;
    exp_q.push_back(want);
    due_q.push_back(cyc + 4);
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 32'($urandom);
    bus.b        = 32'($urandom);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1;
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 32'h3F80_0000;
    bus.b        = 32'h4000_0000;
    @(posedge clock);
    #1;
    exp_q.delete();
    due_q.delete();
    last_exp     = '0;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      logic        want_v;
      logic [33:0] want_r;
      want_v = (due_q.size() != 0) && (due_q[0] == cyc);
      check("out_valid", 64'(bus.out_valid), 64'(want_v));
      if (want_v) begin
        want_r = exp_q.pop_front();
        void'(due_q.pop_front());
        check("result", 64'({bus.out, bus.ovf, bus.zero}), 64'(want_r));
        last_exp = want_r;
      end else begin
        check("hold", 64'({bus.out, bus.ovf, bus.zero}), 64'(last_exp));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    bus.in_valid = 1'b1;
    bus.a        = 32'h4040_0000;
    bus.b        = 32'h3F80_0000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd0);
    mon_en = 1'b1;
    @(posedge clock);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (5) idle();

    send(32'h4040_0000, 32'h3F80_0000, {32'h4000_0000, 2'b00});
    idle();
    send(32'h3F80_0000, 32'h3F80_0000, {32'h0000_0000, 2'b01});
    send(32'h3F80_0000, 32'hBF80_0000, {32'h4000_0000, 2'b00});
    send(32'h3FC0_0000, 32'h3E80_0000, {32'h3FA0_0000, 2'b00});
    send(32'h4040_0000, 32'h3F80_0000, {32'h4000_0000, 2'b00});
    send(32'h7F7F_FFFF, 32'hFF7F_FFFF, {32'h7F80_0000, 2'b10});
    send(32'h0000_0000, 32'h3F80_0000, {32'hBF80_0000, 2'b00});
    send(32'h3F80_0000, 32'h0000_0000, {32'h3F80_0000, 2'b00});
    send(32'h0000_0000, 32'h0000_0000, {32'h0000_0000, 2'b01});
    send(32'h8000_0000, 32'h0000_0000, {32'h8000_0000, 2'b01});
    send(32'h0080_0001, 32'h0080_0000, {32'h0000_0000, 2'b01});
    send(32'h3F80_0000, 32'h3280_0000, {32'h3F80_0000, 2'b00});
`ifdef FP_SUB_SPECIAL_EN
    send(32'h7FC0_0000, 32'h3F80_0000, {32'h7FC0_0000, 2'b00});
    send(32'h7F80_0000, 32'h7F80_0000, {32'h7FC0_0000, 2'b00});
    send(32'h3F80_0000, 32'h7F80_0000, {32'hFF80_0000, 2'b00});
`endif
    repeat (3) idle();

    send(32'h4040_0000, 32'h3F80_0000, {32'h4000_0000, 2'b00});
    send(32'h3FC0_0000, 32'h3E80_0000, {32'h3FA0_0000, 2'b00});
    send(32'h3F80_0000, 32'hBF80_0000, {32'h4000_0000, 2'b00});
    pulse_reset();
    repeat (4) begin
      @(negedge clock);
      check("post_rst_valid", 64'(bus.out_valid), 64'd0);
      check("post_rst_out", 64'(bus.out), 64'd0);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else begin
        ra = rnd_fp($urandom_range(100, 160));
        case ($urandom_range(0, 9))
          0:       rb = ra;
          1:       rb = ra ^ 32'h8000_0000;
          default: rb = rnd_fp(int'(ra[30:23]));
        endcase
        send(ra, rb, ref_sub(ra, rb));
      end
    end

    repeat (8) idle();
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
